jtag_seq: RTL and testbench
===========================

# jtag_seq

JTAG master sequencer that drives the team's TAP controller over its TMS/TDI/TDO pins. It accepts high-level commands (reset, idle, scan IR, scan DR), generates the exact TMS/TDI bit stream for each, and returns the captured TDO bits. It sits between the on-chip test host logic and the TAP, so software-level scans never hand-toggle TMS. The sequencer parks the TAP in Run-Test/Idle between commands.

## Interface
- MAX_LEN, 32, maximum scan length in bits; width of the data buses
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > MAX_LEN
- TCK  in  1  the single clock; all logic on the rising edge
- TRST_N  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 RESET, 01 IDLE, 10 SCAN_IR, 11 SCAN_DR
- cmd_len  in  LEN_W  bit count (scans) or cycle count (IDLE)
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid  out  1  one-cycle pulse: the command completed
- rsp_data  out  MAX_LEN  captured TDO bits, LSB-aligned; upper bits 0
- TMS  out  1  to TAP
- TDI  out  1  to TAP
- TDO  in  1  from TAP
- tap_state  out  4  mirrored TAP state (IEEE 1149.1 encoding)

## Operation
- Controller FSM: INIT, READY, PRE, SHIFT, POST, RUN. A down-counter (LEN_W bits) and a MAX_LEN shift register are shared across states.
- The internal mirror of the 16-state TAP advances on every TCK from the TMS value being driven. tap_state shows the mirror.
- INIT: after reset, the mirror is Test-Logic-Reset. Drive TMS=0 for one cycle to reach Run-Test/Idle, then go to READY.
- READY: cmd_ready=1 and TMS=0, so the TAP holds in Idle. Commands are latched on acceptance.
- RESET: TMS=1 for 5 cycles, then TMS=0 for 1 cycle. Total 6 cycles, ending in Idle. rsp_data=0.
- IDLE: TMS=0 for max(cmd_len,1) cycles. rsp_data=0.
- SCAN_DR, PRE state: TMS sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR).
- SCAN_IR, PRE state: TMS sequence 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- SHIFT: drive cmd_data LSB-first on TDI. TMS=0 for every bit except the last, where TMS=1 (Exit1).
- POST: TMS sequence 1,0 (Update, then Idle).
- Scan length: cmd_len=0 gives zero shift bits, so Capture goes to Exit1 directly with TMS=1. cmd_len>MAX_LEN is clamped to MAX_LEN.
- TDO capture: TDO is sampled at the rising edge on which the TAP consumes TDI bit i. That bit is stored at rsp_data[i].
- TDI outside SHIFT is 1.

## Timing
- Reset values:
  - TMS=1, TDI=1
  - cmd_ready=0, rsp_valid=0, rsp_data=0
  - tap_state=Test-Logic-Reset (4'hF)
  - FSM=INIT
- cmd_ready first rises on the 2nd rising TCK after TRST_N deasserts.
- Command cycle counts, from the acceptance edge to the final TMS cycle:
  - SCAN_DR: n+5
  - SCAN_IR: n+6
  - RESET: 6
  - IDLE: max(n,1)
- rsp_valid pulses on the cycle after the final TMS cycle. cmd_ready is high in that same cycle, so back-to-back commands lose no cycles.
- There is no response backpressure. rsp_data holds until the next rsp_valid.
- cmd_ready is low for the whole of every command. cmd_valid while busy is ignored and the command is not latched.
- TRST_N asserted mid-command aborts it immediately:
  - no rsp_valid is produced
  - the mirror returns to Test-Logic-Reset
  - the INIT sequence replays on release

## Structure
- Shared package jtag_pkg holds:
  - TAP state encodings (16 enums, IEEE values)
  - cmd_op codes
  - the next-state function of TMS
- The package is shared with the TAP itself.
- One sub-module: jtag_tap_mirror, the 16-state registered TAP model driven by TMS. It can be reused by the TAP and by benches.

## Test plan
- Reset release with cmd_valid=0:
  - TMS=1 during reset, then one TMS=0 cycle
  - cmd_ready=1 on the 2nd edge
  - tap_state=Run-Test/Idle (4'hC)
- RESET command: TMS stream 1,1,1,1,1,0. rsp_valid 7 cycles after acceptance; rsp_data=0; tap_state ends at 4'hC.
- SCAN_IR len=4, data=4'hF (BYPASS), into the bench TAP:
  - TMS stream 1,1,0,0,0,0,0,1,1,0
  - TDI 1,1,1,1 during SHIFT
  - rsp_data = captured IR value (4'b0001)
- SCAN_DR len=8, data=8'hA5, with BYPASS selected:
  - rsp_data=8'h4A (one-bit bypass delay, leading capture 0)
  - 13 TMS cycles
- Edge lengths:
  - SCAN_DR len=0: TMS stream 1,0,1,1,0; rsp_data=0
  - IDLE len=0: exactly 1 TMS=0 cycle
  - len=40 with MAX_LEN=32: clamped to 32
- Abort: TRST_N pulsed low during SHIFT bit 3 of a 16-bit DR scan:
  - no rsp_valid
  - outputs at reset values
  - INIT replayed
  - the next SCAN_DR completes correctly
- Back-to-back IDLE len=2 commands with cmd_valid held high: the second is accepted in the same cycle as the first's rsp_valid.

Source files
------------

// File: rtl/jtag_pkg.sv
// jtag_pkg: IEEE 1149.1 TAP state encodings, sequencer opcodes and the
// TMS-driven TAP next-state function shared by sequencer, TAP and mirror.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR  = 4'h0,
        TAP_EXIT1_DR  = 4'h1,
        TAP_SHIFT_DR  = 4'h2,
        TAP_PAUSE_DR  = 4'h3,
        TAP_SEL_IR    = 4'h4,
        TAP_UPDATE_DR = 4'h5,
        TAP_CAP_DR    = 4'h6,
        TAP_SEL_DR    = 4'h7,
        TAP_EXIT2_IR  = 4'h8,
        TAP_EXIT1_IR  = 4'h9,
        TAP_SHIFT_IR  = 4'hA,
        TAP_PAUSE_IR  = 4'hB,
        TAP_RTI       = 4'hC,
        TAP_UPDATE_IR = 4'hD,
        TAP_CAP_IR    = 4'hE,
        TAP_TLR       = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        OP_RESET   = 2'b00,
        OP_IDLE    = 2'b01,
        OP_SCAN_IR = 2'b10,
        OP_SCAN_DR = 2'b11
    } cmd_op_e;

    function automatic tap_state_e tap_next(input tap_state_e s,
                                            input logic tms);
        tap_state_e n;
        case (s)
            TAP_TLR:       n = tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:       n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:    n = tms ? TAP_SEL_IR    : TAP_CAP_DR;
            TAP_CAP_DR:    n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:    n = tms ? TAP_TLR       : TAP_CAP_IR;
            TAP_CAP_IR:    n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR: n = tms ? TAP_SEL_DR    : TAP_RTI;
            default:       n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_tap_mirror.sv
// jtag_tap_mirror: registered 16-state TAP model advanced by TMS on
// every rising clock; resets to Test-Logic-Reset.
module jtag_tap_mirror
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms,
    output tap_state_e state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TAP_TLR;
        end else begin
            state <= tap_next(state, tms);
        end
    end

endmodule

// File: rtl/jtag_seq.sv
// jtag_seq: JTAG master sequencer turning reset/idle/scan commands into
// registered TMS/TDI streams and returning captured TDO bits.
module jtag_seq
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               TCK,
    input  logic               TRST_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic [3:0]         tap_state
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_PRE   = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_POST  = 3'd4;
    localparam logic [2:0] ST_RUN   = 3'd5;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO     = LEN_W'(2);
    localparam logic [LEN_W:0]   SH_MAX  = (LEN_W + 1)'(MAX_LEN);

    logic [2:0]         st_q, st_n;
    logic [LEN_W-1:0]   cnt_q, cnt_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [1:0]         op_q, op_n;
    logic [MAX_LEN-1:0] sr_q, sr_n;
    logic [MAX_LEN-1:0] rsp_q, rsp_n;
    logic [LEN_W:0]     sh;
    logic               tms_q, tms_n;
    logic               tdi_q, tdi_n;
    logic               rv_q, rv_n;
    tap_state_e         mirror_st;

    assign cmd_ready = (st_q == ST_READY);
    assign rsp_valid = rv_q;
    assign rsp_data  = rsp_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;
    assign tap_state = mirror_st;

    // Captured bits sit at the top of sr; slide them down to bit 0.
    assign sh = SH_MAX - {1'b0, len_q};

    always_comb begin
        st_n  = st_q;
        cnt_n = cnt_q;
        len_n = len_q;
        op_n  = op_q;
        sr_n  = sr_q;
        rsp_n = rsp_q;
        rv_n  = 1'b0;
        unique case (st_q)
            ST_INIT: begin
                if (cnt_q == '0) begin
                    st_n = ST_READY;
                end else begin
                    cnt_n = cnt_q - ONE;
                end
            end
            ST_READY: begin
                if (cmd_valid) begin
                    op_n  = cmd_op;
                    sr_n  = cmd_data;
                    len_n = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                    unique case (cmd_op)
                        OP_RESET: begin
                            st_n  = ST_RUN;
                            cnt_n = LEN_W'(5);
                        end
                        OP_IDLE: begin
                            st_n  = ST_RUN;
                            cnt_n = (cmd_len == '0) ? '0 : cmd_len - ONE;
                        end
                        OP_SCAN_IR: begin
                            st_n  = ST_PRE;
                            cnt_n = LEN_W'(3);
                        end
                        default: begin
                            st_n  = ST_PRE;
                            cnt_n = TWO;
                        end
                    endcase
                end
            end
            ST_PRE: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - ONE;
                end else if (len_q == '0) begin
                    st_n  = ST_POST;
                    cnt_n = ONE;
                end else begin
                    st_n  = ST_SHIFT;
                    cnt_n = len_q - ONE;
                end
            end
            ST_SHIFT: begin
                sr_n = {TDO, sr_q[MAX_LEN-1:1]};
                if (cnt_q == '0) begin
                    st_n  = ST_POST;
                    cnt_n = ONE;
                end else begin
                    cnt_n = cnt_q - ONE;
                end
            end
            ST_POST: begin
                if (cnt_q == '0) begin
                    st_n  = ST_READY;
                    rv_n  = 1'b1;
                    rsp_n = sr_q >> sh;
                end else begin
                    cnt_n = cnt_q - ONE;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    st_n  = ST_READY;
                    rv_n  = 1'b1;
                    rsp_n = '0;
                end else begin
                    cnt_n = cnt_q - ONE;
                end
            end
            default: begin
                st_n  = ST_INIT;
                cnt_n = '0;
            end
        endcase

        // Pins are registered: derive them from the state being entered.
        tms_n = 1'b0;
        tdi_n = 1'b1;
        unique case (st_n)
            ST_PRE:   tms_n = (cnt_n >= TWO) ||
                              (cnt_n == '0 && len_n == '0);
            ST_SHIFT: begin
                tms_n = (cnt_n == '0);
                tdi_n = sr_n[0];
            end
            ST_POST:  tms_n = (cnt_n != '0);
            ST_RUN:   tms_n = (op_n == OP_RESET) && (cnt_n != '0);
            default:  tms_n = 1'b0;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            st_q  <= ST_INIT;
            cnt_q <= ONE;
            len_q <= '0;
            op_q  <= '0;
            sr_q  <= '0;
            rsp_q <= '0;
            tms_q <= 1'b1;
            tdi_q <= 1'b1;
            rv_q  <= 1'b0;
        end else begin
            st_q  <= st_n;
            cnt_q <= cnt_n;
            len_q <= len_n;
            op_q  <= op_n;
            sr_q  <= sr_n;
            rsp_q <= rsp_n;
            tms_q <= tms_n;
            tdi_q <= tdi_n;
            rv_q  <= rv_n;
        end
    end

    jtag_tap_mirror u_mirror (
        .clk   (TCK),
        .rst_n (TRST_N),
        .tms   (tms_q),
        .state (mirror_st)
    );

endmodule

// File: tb/tb_jtag_seq.sv
// tb_jtag_seq: directed bench for jtag_seq with a small behavioural TAP
// (4-bit IR capturing 0001, one-bit BYPASS data register).
module tb_jtag_seq;

    localparam logic [1:0] OPR  = 2'b00;
    localparam logic [1:0] OPI  = 2'b01;
    localparam logic [1:0] OPIR = 2'b10;
    localparam logic [1:0] OPDR = 2'b11;

    logic        TCK = 1'b0;
    logic        TRST_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic [3:0]  tap_state;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] bt;
    logic [3:0] ir;
    logic [3:0] ir_sr;
    logic       byp;

    always #5 TCK = ~TCK;

    jtag_seq dut (
        .TCK       (TCK),
        .TRST_N    (TRST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .tap_state (tap_state)
    );

    function automatic logic [3:0] tap_nx(input logic [3:0] s,
                                          input logic m);
        case (s)
            4'hF: return m ? 4'hF : 4'hC;
            4'hC: return m ? 4'h7 : 4'hC;
            4'h7: return m ? 4'h4 : 4'h6;
            4'h6: return m ? 4'h1 : 4'h2;
            4'h2: return m ? 4'h1 : 4'h2;
            4'h1: return m ? 4'h5 : 4'h3;
            4'h3: return m ? 4'h0 : 4'h3;
            4'h0: return m ? 4'h5 : 4'h2;
            4'h5: return m ? 4'h7 : 4'hC;
            4'h4: return m ? 4'hF : 4'hE;
            4'hE: return m ? 4'h9 : 4'hA;
            4'hA: return m ? 4'h9 : 4'hA;
            4'h9: return m ? 4'hD : 4'hB;
            4'hB: return m ? 4'h8 : 4'hB;
            4'h8: return m ? 4'hD : 4'hA;
            default: return m ? 4'h7 : 4'hC;
        endcase
    endfunction

    always @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bt    <= 4'hF;
            ir    <= 4'hF;
            ir_sr <= 4'h0;
            byp   <= 1'b0;
        end else begin
            case (bt)
                4'hE: ir_sr <= 4'b0001;
                4'hA: ir_sr <= {TDI, ir_sr[3:1]};
                4'hD: ir    <= ir_sr;
                4'h6: byp   <= 1'b0;
                4'h2: byp   <= TDI;
                default: ;
            endcase
            bt <= tap_nx(bt, TMS);
        end
    end

    assign TDO = (bt == 4'hA) ? ir_sr[0] :
                 (bt == 4'h2) ? byp : 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue at a negedge with cmd_ready high; return at the rsp_valid negedge.
    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len,
                           input logic [31:0] data, output int ncyc,
                           output logic [63:0] tms_s,
                           output logic [63:0] tdi_s,
                           output logic rdy_busy);
        chk("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge TCK);
        cmd_valid = 1'b0;
        ncyc      = 0;
        tms_s     = '0;
        tdi_s     = '0;
        rdy_busy  = 1'b0;
        while (!rsp_valid && ncyc < 64) begin
            tms_s[ncyc] = TMS;
            tdi_s[ncyc] = TDI;
            if (cmd_ready) rdy_busy = 1'b1;
            ncyc++;
            @(negedge TCK);
        end
    endtask

    initial begin
        int          nc;
        logic [63:0] ts;
        logic [63:0] ds;
        logic        rb;
        logic        rv_seen;

        TRST_N    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 6'd0;
        cmd_data  = 32'd0;

        repeat (2) @(negedge TCK);
        chk("rst_tms", {31'd0, TMS}, 32'd1);
        chk("rst_tdi", {31'd0, TDI}, 32'd1);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_tap", {28'd0, tap_state}, 32'hF);
        TRST_N = 1'b1;
        #1 chk("rel_tms_before_edge", {31'd0, TMS}, 32'd1);
        @(negedge TCK);
        chk("init_tms0", {31'd0, TMS}, 32'd0);
        chk("init_ready_edge1", {31'd0, cmd_ready}, 32'd0);
        chk("init_tap_edge1", {28'd0, tap_state}, 32'hF);
        @(negedge TCK);
        chk("init_ready_edge2", {31'd0, cmd_ready}, 32'd1);
        chk("init_tap_idle", {28'd0, tap_state}, 32'hC);
        chk("init_tms_ready", {31'd0, TMS}, 32'd0);

        run_cmd(OPR, 6'd0, 32'd0, nc, ts, ds, rb);
        chk("reset_cycles", 32'(nc), 32'd6);
        chk("reset_tms", ts[31:0], 32'h1F);
        chk("reset_rsp", rsp_data, 32'd0);
        chk("reset_tap", {28'd0, tap_state}, 32'hC);
        chk("reset_busy_ready", {31'd0, rb}, 32'd0);

        run_cmd(OPIR, 6'd4, 32'hF, nc, ts, ds, rb);
        chk("ir_cycles", 32'(nc), 32'd10);
        chk("ir_tms", ts[31:0], 32'h183);
        chk("ir_tdi", ds[31:0], 32'h3FF);
        chk("ir_rsp", rsp_data, 32'h1);
        chk("ir_tap", {28'd0, tap_state}, 32'hC);
        chk("ir_bench_ir", {28'd0, ir}, 32'hF);
        chk("ir_busy_ready", {31'd0, rb}, 32'd0);
        @(negedge TCK);
        chk("rsp_pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("rsp_hold", rsp_data, 32'h1);

        run_cmd(OPDR, 6'd8, 32'hA5, nc, ts, ds, rb);
        chk("dr8_cycles", 32'(nc), 32'd13);
        chk("dr8_tms", ts[31:0], 32'hC01);
        chk("dr8_tdi", ds[31:0], 32'h1D2F);
        chk("dr8_rsp", rsp_data, 32'h4A);
        chk("dr8_tap_vs_model", {28'd0, tap_state}, {28'd0, bt});

        run_cmd(OPDR, 6'd0, 32'hFFFF_FFFF, nc, ts, ds, rb);
        chk("dr0_cycles", 32'(nc), 32'd5);
        chk("dr0_tms", ts[31:0], 32'hD);
        chk("dr0_rsp", rsp_data, 32'd0);
        chk("dr0_tap", {28'd0, tap_state}, 32'hC);

        run_cmd(OPI, 6'd0, 32'd0, nc, ts, ds, rb);
        chk("idle0_cycles", 32'(nc), 32'd1);
        chk("idle0_tms", ts[31:0], 32'd0);

        run_cmd(OPDR, 6'd40, 32'hC3A5_0F81, nc, ts, ds, rb);
        chk("dr40_cycles", 32'(nc), 32'd37);
        chk("dr40_rsp", rsp_data, 32'h874A_1F02);
        chk("dr40_tap", {28'd0, tap_state}, 32'hC);

        cmd_op    = OPDR;
        cmd_len   = 6'd16;
        cmd_data  = 32'hBEEF;
        cmd_valid = 1'b1;
        @(negedge TCK);
        cmd_valid = 1'b0;
        rv_seen   = 1'b0;
        repeat (6) begin
            @(negedge TCK);
            if (rsp_valid) rv_seen = 1'b1;
        end
        chk("abort_in_shift_dr", {28'd0, tap_state}, 32'h2);
        TRST_N = 1'b0;
        #1;
        chk("abort_tms", {31'd0, TMS}, 32'd1);
        chk("abort_tdi", {31'd0, TDI}, 32'd1);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_tap", {28'd0, tap_state}, 32'hF);
        @(negedge TCK);
        if (rsp_valid) rv_seen = 1'b1;
        TRST_N = 1'b1;
        @(negedge TCK);
        if (rsp_valid) rv_seen = 1'b1;
        chk("reinit_tms0", {31'd0, TMS}, 32'd0);
        chk("reinit_ready_edge1", {31'd0, cmd_ready}, 32'd0);
        @(negedge TCK);
        if (rsp_valid) rv_seen = 1'b1;
        chk("reinit_ready_edge2", {31'd0, cmd_ready}, 32'd1);
        chk("reinit_tap", {28'd0, tap_state}, 32'hC);
        chk("abort_no_rsp", {31'd0, rv_seen}, 32'd0);

        run_cmd(OPDR, 6'd8, 32'h3C, nc, ts, ds, rb);
        chk("post_abort_cycles", 32'(nc), 32'd13);
        chk("post_abort_rsp", rsp_data, 32'h78);

        @(negedge TCK);
        cmd_op    = OPI;
        cmd_len   = 6'd2;
        cmd_data  = 32'd0;
        cmd_valid = 1'b1;
        @(negedge TCK);
        chk("b2b_c1", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        @(negedge TCK);
        chk("b2b_c2", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        @(negedge TCK);
        chk("b2b_first_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd3);
        @(negedge TCK);
        chk("b2b_second_taken", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        @(negedge TCK);
        chk("b2b_c5", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        @(negedge TCK);
        chk("b2b_second_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd3);
        chk("b2b_rsp_data", rsp_data, 32'd0);
        @(negedge TCK);
        chk("b2b_no_third", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        chk("b2b_tap", {28'd0, tap_state}, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
